uart_alu_interface: RTL

- Frame-assembly and response stage directly downstream of the UART receiver and upstream of the UART transmitter.
- Collects three received bytes in fixed order: operand A, operand B, opcode.
- Holds them on registered outputs that drive a combinational ALU.
- Captures the ALU result and launches a single transmit of that result.
- Guards against partial frames with an inter-byte timeout and flags bytes lost while a transmit is in flight.

---
 rtl/uart_alu_interface.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - UART frame assembler feeding a combinational ALU and launching the result transmit
module uart_alu_interface #(
    parameter int NBIT_DATA      = 8,
    parameter int NBIT_OPCODE    = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [NBIT_DATA-1:0]   rx_data,
    input  logic                   rx_done_tick,
    input  logic                   tx_done_tick,
    input  logic [NBIT_DATA-1:0]   alu_result,
    output logic [NBIT_DATA-1:0]   alu_a,
    output logic [NBIT_DATA-1:0]   alu_b,
    output logic [NBIT_OPCODE-1:0] alu_op,
    output logic [NBIT_DATA-1:0]   tx_data,
    output logic                   tx_start,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overrun_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        LOAD,
        WAIT_TX
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              in_frame;
    logic              tmo_expire;
    logic              load_a;
    logic              load_b;
    logic              load_op;
    logic              load_tx;
    logic              overrun_set;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign in_frame   = (state == WAIT_B) || (state == WAIT_OP);
    assign tmo_expire = in_frame && !rx_done_tick && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_A: begin
                if (rx_done_tick) state_next = WAIT_B;
            end
            WAIT_B: begin
                if (rx_done_tick)    state_next = WAIT_OP;
                else if (tmo_expire) state_next = WAIT_A;
            end
            WAIT_OP: begin
                if (rx_done_tick)    state_next = LOAD;
                else if (tmo_expire) state_next = WAIT_A;
            end
            LOAD: begin
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) state_next = WAIT_A;
            end
            default: state_next = WAIT_A;
        endcase
    end

    always_comb begin
        busy        = (state != WAIT_A);
        load_a      = (state == WAIT_A)  && rx_done_tick;
        load_b      = (state == WAIT_B)  && rx_done_tick;
        load_op     = (state == WAIT_OP) && rx_done_tick;
        load_tx     = (state == LOAD);
        overrun_set = rx_done_tick && ((state == LOAD) || (state == WAIT_TX));
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (load_a)  alu_a   <= rx_data;
            if (load_b)  alu_b   <= rx_data;
            if (load_op) alu_op  <= rx_data[NBIT_OPCODE-1:0];
            if (load_tx) tx_data <= alu_result;
            tx_start    <= load_tx;
            timeout_err <= tmo_expire;
            if (overrun_set) overrun_err <= 1'b1;
        end
    end

    // Counter only runs between bytes of a frame; any other state holds it at zero.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (in_frame && !rx_done_tick && !tmo_expire) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

endmodule
